// File: rtl/router_egress_sched.sv
// router_egress_sched: round-robin, whole-packet scheduler from three output FIFOs onto one egress port
module router_egress_sched (
    input  logic       clk,
    input  logic       resetn,
    input  logic       vld_out_0,
    input  logic       vld_out_1,
    input  logic       vld_out_2,
    input  logic [7:0] data_out_0,
    input  logic [7:0] data_out_1,
    input  logic [7:0] data_out_2,
    input  logic       soft_reset_0,
    input  logic       soft_reset_1,
    input  logic       soft_reset_2,
    input  logic       egress_ready,
    output logic       read_enb_0,
    output logic       read_enb_1,
    output logic       read_enb_2,
    output logic [7:0] egress_data,
    output logic       egress_valid,
    output logic       egress_sop,
    output logic       egress_eop,
    output logic [1:0] egress_port,
    output logic       pkt_abort,
    output logic       busy
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] HDR   = 3'd1;
    localparam logic [2:0] LEN   = 3'd2;
    localparam logic [2:0] BODY  = 3'd3;
    localparam logic [2:0] DRAIN = 3'd4;

    logic [2:0] state_q, state_d;
    logic [1:0] grant_q, grant_d;
    logic [6:0] rem_q, rem_d;
    logic [1:0] cnt_q, cnt_d;
    logic [9:0] buf0_q, buf0_d, buf1_q, buf1_d;
    logic       infl_q, infl_d, infl_sop_q, infl_sop_d, infl_eop_q, infl_eop_d;
    logic       abort_q, abort_d;
    logic [2:0] vld, srst, elig, occ;
    logic [7:0] data_g;
    logic [9:0] push;
    logic [1:0] p1, p2;
    logic       abort, pop, rd;

    always_comb begin
        vld = {vld_out_2, vld_out_1, vld_out_0};
        srst = {soft_reset_2, soft_reset_1, soft_reset_0};
        elig = vld & ~srst;
        data_g = grant_q == 2'd0 ? data_out_0 : grant_q == 2'd1 ? data_out_1 : data_out_2;
        abort = state_q != IDLE && srst[grant_q];
        // a byte on the port during an abort is withdrawn, so it can never be consumed
        egress_valid = resetn && cnt_q != 2'd0 && !abort;
        pop = egress_valid && egress_ready;
        occ = {1'b0, cnt_q} + {2'b0, infl_q} - {2'b0, pop};
        rd = resetn && !abort && occ < 3'd2 &&
             (state_q == HDR || (state_q == BODY && vld[grant_q] && rem_q != 7'd0));
        {read_enb_2, read_enb_1, read_enb_0} = {3{rd}} & (3'b001 << grant_q);
        egress_data = egress_valid ? buf0_q[7:0] : 8'h00;
        egress_sop = egress_valid && buf0_q[8];
        egress_eop = egress_valid && buf0_q[9];
        egress_port = egress_valid ? grant_q : 2'd0;
        pkt_abort = resetn && abort_q;
        busy = resetn && state_q != IDLE;
        p1 = grant_q == 2'd2 ? 2'd0 : grant_q + 2'd1;
        p2 = p1 == 2'd2 ? 2'd0 : p1 + 2'd1;
        push = {infl_eop_q, infl_sop_q, data_g};
        buf0_d = buf0_q;
        buf1_d = buf1_q;
        cnt_d = cnt_q;
        if (pop) begin
            buf0_d = buf1_q;
            cnt_d = cnt_d - 2'd1;
        end
        if (infl_q) begin
            if (cnt_d == 2'd0) buf0_d = push;
            else buf1_d = push;
            cnt_d = cnt_d + 2'd1;
        end
        state_d = state_q;
        grant_d = grant_q;
        rem_d = rem_q;
        if (state_q == IDLE && elig != 3'd0) begin
            grant_d = elig[p1] ? p1 : elig[p2] ? p2 : grant_q;
            state_d = HDR;
        end
        if (state_q == HDR && rd) state_d = LEN;
        if (state_q == LEN) begin
            rem_d = {1'b0, data_g[7:2]} + 7'd1;
            state_d = BODY;
        end
        if (state_q == BODY) begin
            rem_d = rem_q - {6'd0, rd};
            state_d = rem_d == 7'd0 ? DRAIN : BODY;
        end
        if (state_q == DRAIN && cnt_q == 2'd0 && !infl_q) state_d = IDLE;
        if (abort) begin
            state_d = IDLE;
            rem_d = 7'd0;
            cnt_d = 2'd0;
        end
        infl_d = rd;
        infl_sop_d = state_q == HDR;
        infl_eop_d = state_q == BODY && rem_q == 7'd1;
        abort_d = abort;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
            grant_q <= 2'd2;
            rem_q <= 7'd0;
            cnt_q <= 2'd0;
            buf0_q <= 10'd0;
            buf1_q <= 10'd0;
            infl_q <= 1'b0;
            infl_sop_q <= 1'b0;
            infl_eop_q <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rem_q <= rem_d;
            cnt_q <= cnt_d;
            buf0_q <= buf0_d;
            buf1_q <= buf1_d;
            infl_q <= infl_d;
            infl_sop_q <= infl_sop_d;
            infl_eop_q <= infl_eop_d;
            abort_q <= abort_d;
        end
    end
endmodule
